// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: walks sel across the minutes and
// hours BCD digits, inserts a blanking gap after each digit and blinks masked
// digits at a frame-derived slow rate.
//
// state | meaning
// IDLE  | display disabled, decoder off, blank code out
// SHOW  | current digit driven for REFRESH_DIV cycles
// BLANK | anti-ghosting gap for BLANK_CYC cycles, sel already on next digit
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] mm_ones,
  input  logic [3:0] mm_tens,
  input  logic [3:0] hh_ones,
  input  logic [3:0] hh_tens,
  input  logic [3:0] blink_mask,
  input  logic       colon_on,
  output logic [1:0] sel,
  output logic       dec_en,
  output logic [3:0] bcd_out,
  output logic       dp,
  output logic       frame_done
);

  localparam int DIV_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int DW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DW-1:0] SHOW_LAST  = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] BLANK_LAST = DW'(BLANK_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [3:0]    BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, BLANK = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [1:0]    sel_d;
  logic          dec_en_d, dp_d, fd_d;
  logic [3:0]    bcd_d;

  logic [1:0]    show_sel;
  logic [3:0]    raw_digit;
  logic [3:0]    show_code;
  logic          show_dp;

  // Code and decimal point for whichever digit the next SHOW cycle displays;
  // leaving IDLE always restarts at digit 0.
  always_comb begin
    show_sel = (state_q == IDLE) ? 2'd0 : sel;
    case (show_sel)
      2'd0:    raw_digit = mm_ones;
      2'd1:    raw_digit = mm_tens;
      2'd2:    raw_digit = hh_ones;
      default: raw_digit = hh_tens;
    endcase
    if ((raw_digit > 4'd9) || (phase_q && blink_mask[show_sel])) begin
      show_code = BLANK_CODE;
    end else begin
      show_code = raw_digit;
    end
    show_dp = colon_on && (show_sel == 2'd2);
  end

  // Next-state and next-output logic; disable overrides any scheduled advance.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    sel_d    = sel;
    dec_en_d = 1'b0;
    bcd_d    = BLANK_CODE;
    dp_d     = 1'b0;
    fd_d     = 1'b0;
    if (!en) begin
      state_d = IDLE;
      div_d   = '0;
      cnt_d   = '0;
      sel_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SHOW;
          sel_d    = 2'd0;
          div_d    = '0;
          dec_en_d = 1'b1;
          bcd_d    = show_code;
          dp_d     = show_dp;
        end
        SHOW: begin
          dec_en_d = 1'b1;
          if (div_q == SHOW_LAST) begin
            state_d = BLANK;
            div_d   = '0;
            sel_d   = sel + 2'd1;
            if (sel == 2'd3) begin
              fd_d = 1'b1;
              if (cnt_q == BLINK_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
              end else begin
                cnt_d = cnt_q + BW'(1);
              end
            end
          end else begin
            div_d = div_q + DW'(1);
            bcd_d = show_code;
            dp_d  = show_dp;
          end
        end
        BLANK: begin
          dec_en_d = 1'b1;
          if (div_q == BLANK_LAST) begin
            state_d = SHOW;
            div_d   = '0;
            bcd_d   = show_code;
            dp_d    = show_dp;
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          div_d   = '0;
          sel_d   = 2'd0;
        end
      endcase
    end
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      sel        <= 2'd0;
      dec_en     <= 1'b0;
      bcd_out    <= BLANK_CODE;
      dp         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      sel        <= sel_d;
      dec_en     <= dec_en_d;
      bcd_out    <= bcd_d;
      dp         <= dp_d;
      frame_done <= fd_d;
    end
  end

endmodule
